// File: rtl/axil_axi_id_tracker_pkg.sv
// Shared constants and helpers for the AXI4 -> AXI-Lite ID tracker.
// Covers occupancy/pointer width derivation and the FIFO depth legality rule.
package axi_id_tracker_pkg;

    localparam int MIN_FIFO_DEPTH     = 2;
    localparam int MAX_FIFO_DEPTH     = 64;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    // Pointers carry one extra wrap bit above the slot index.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Index of the wrap bit inside a pointer.
    function automatic int ptr_msb(input int depth);
        return cnt_width(depth) - 1;
    endfunction

    // The MSB-wrap full/empty scheme needs a power-of-two depth.
    function automatic bit fifo_depth_legal(input int depth);
        return (depth >= MIN_FIFO_DEPTH) && (depth <= MAX_FIFO_DEPTH) &&
               ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/axil_axi_id_tracker_if.sv
// Bus bundle for the ID tracker: AXI4 master side (s_axi_*) and
// AXI-Lite slave side (m_axil_*). The tracker uses the slave modport;
// whatever drives the master and the Lite slave uses the master modport.
interface axil_axi_id_tracker_if #(
    parameter int AXI_ID_WIDTH = 8
);
    logic [AXI_ID_WIDTH-1:0] s_axi_awid;
    logic                    s_axi_awvalid;
    logic                    s_axi_awready;
    logic                    m_axil_awvalid;
    logic                    m_axil_awready;

    logic [AXI_ID_WIDTH-1:0] s_axi_arid;
    logic                    s_axi_arvalid;
    logic                    s_axi_arready;
    logic                    m_axil_arvalid;
    logic                    m_axil_arready;

    logic                    m_axil_bvalid;
    logic                    m_axil_bready;
    logic                    s_axi_bvalid;
    logic                    s_axi_bready;
    logic [AXI_ID_WIDTH-1:0] s_axi_bid;

    logic                    m_axil_rvalid;
    logic                    m_axil_rready;
    logic                    s_axi_rvalid;
    logic                    s_axi_rready;
    logic [AXI_ID_WIDTH-1:0] s_axi_rid;
    logic                    s_axi_rlast;

    modport slave (
        input  s_axi_awid, s_axi_awvalid, m_axil_awready,
        input  s_axi_arid, s_axi_arvalid, m_axil_arready,
        input  m_axil_bvalid, s_axi_bready,
        input  m_axil_rvalid, s_axi_rready,
        output s_axi_awready, m_axil_awvalid,
        output s_axi_arready, m_axil_arvalid,
        output m_axil_bready, s_axi_bvalid, s_axi_bid,
        output m_axil_rready, s_axi_rvalid, s_axi_rid, s_axi_rlast
    );

    modport master (
        output s_axi_awid, s_axi_awvalid, m_axil_awready,
        output s_axi_arid, s_axi_arvalid, m_axil_arready,
        output m_axil_bvalid, s_axi_bready,
        output m_axil_rvalid, s_axi_rready,
        input  s_axi_awready, m_axil_awvalid,
        input  s_axi_arready, m_axil_arvalid,
        input  m_axil_bready, s_axi_bvalid, s_axi_bid,
        input  m_axil_rready, s_axi_rvalid, s_axi_rid, s_axi_rlast
    );
endinterface

// File: rtl/axil_axi_id_tracker_fifo.sv
// Register FIFO holding outstanding transaction IDs.
// Pointers are one bit wider than the slot index; the extra MSB tracks wrap.
// Head reads as zero while empty; storage is not reset.
module axi_id_fifo
    import axi_id_tracker_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int DEPTH     = DEFAULT_FIFO_DEPTH,
    localparam int CNT_WIDTH = cnt_width(DEPTH),
    localparam int PTR_MSB   = ptr_msb(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     head,
    output logic                 full,
    output logic                 empty,
    output logic [CNT_WIDTH-1:0] count
);

    if (!fifo_depth_legal(DEPTH)) begin : g_depth_check
        $error("axi_id_fifo: DEPTH must be a power of two in 2..64");
    end

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [CNT_WIDTH-1:0] wr_ptr;
    logic [CNT_WIDTH-1:0] rd_ptr;
    logic [PTR_MSB-1:0]   wr_idx;
    logic [PTR_MSB-1:0]   rd_idx;

    assign wr_idx = wr_ptr[PTR_MSB-1:0];
    assign rd_idx = rd_ptr[PTR_MSB-1:0];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_MSB] != rd_ptr[PTR_MSB]) && (wr_idx == rd_idx);
    assign count = wr_ptr - rd_ptr;
    assign head  = empty ? '0 : mem[rd_idx];

    // Capture the pushed ID into its slot; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= push_data;
        end
    end

    // Advance write/read pointers on push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/axil_axi_id_tracker.sv
// AXI4 -> AXI-Lite ID adapter. Remembers AWID/ARID per outstanding
// transaction in two independent FIFOs and returns them on B/R in order.
// Address acceptance stalls while a FIFO is full; responses stall while
// the matching FIFO is empty (no bypass of a same-cycle push).
// Optional: define AXIL_AXI_ID_TRACKER_ERR_EN to build sticky orphan-response
// detection; otherwise err_b_orphan/err_r_orphan are tied low.
module axil_axi_id_tracker
    import axi_id_tracker_pkg::*;
#(
    parameter  int AXI_ID_WIDTH = 8,
    parameter  int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
    localparam int CNT_WIDTH    = cnt_width(FIFO_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    axil_axi_id_tracker_if.slave      bus,
    output logic [CNT_WIDTH-1:0]      aw_outstanding,
    output logic [CNT_WIDTH-1:0]      ar_outstanding,
    output logic                      err_b_orphan,
    output logic                      err_r_orphan
);

    logic aw_full;
    logic aw_empty;
    logic ar_full;
    logic ar_empty;
    logic aw_push;
    logic b_pop;
    logic ar_push;
    logic r_pop;

    // Write address / response gating.
    assign bus.s_axi_awready  = bus.m_axil_awready & ~aw_full;
    assign bus.m_axil_awvalid = bus.s_axi_awvalid  & ~aw_full;
    assign bus.m_axil_bready  = bus.s_axi_bready   & ~aw_empty;
    assign bus.s_axi_bvalid   = bus.m_axil_bvalid  & ~aw_empty;

    // Read address / response gating; AXI-Lite reads are always single-beat.
    assign bus.s_axi_arready  = bus.m_axil_arready & ~ar_full;
    assign bus.m_axil_arvalid = bus.s_axi_arvalid  & ~ar_full;
    assign bus.m_axil_rready  = bus.s_axi_rready   & ~ar_empty;
    assign bus.s_axi_rvalid   = bus.m_axil_rvalid  & ~ar_empty;
    assign bus.s_axi_rlast    = bus.s_axi_rvalid;

    assign aw_push = bus.s_axi_awvalid & bus.s_axi_awready;
    assign b_pop   = bus.s_axi_bvalid  & bus.s_axi_bready;
    assign ar_push = bus.s_axi_arvalid & bus.s_axi_arready;
    assign r_pop   = bus.s_axi_rvalid  & bus.s_axi_rready;

    axi_id_fifo #(
        .WIDTH (AXI_ID_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_aw_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (aw_push),
        .push_data (bus.s_axi_awid),
        .pop       (b_pop),
        .head      (bus.s_axi_bid),
        .full      (aw_full),
        .empty     (aw_empty),
        .count     (aw_outstanding)
    );

    axi_id_fifo #(
        .WIDTH (AXI_ID_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_ar_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (ar_push),
        .push_data (bus.s_axi_arid),
        .pop       (r_pop),
        .head      (bus.s_axi_rid),
        .full      (ar_full),
        .empty     (ar_empty),
        .count     (ar_outstanding)
    );

`ifdef AXIL_AXI_ID_TRACKER_ERR_EN
    // A response against an empty FIFO for one cycle is the normal
    // no-bypass stall; only a second consecutive cycle counts as orphan.
    logic b_orphan_now;
    logic r_orphan_now;
    logic b_orphan_prev;
    logic r_orphan_prev;

    assign b_orphan_now = bus.m_axil_bvalid & aw_empty;
    assign r_orphan_now = bus.m_axil_rvalid & ar_empty;

    // Remember last cycle's orphan condition and latch sticky error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b_orphan_prev <= 1'b0;
            r_orphan_prev <= 1'b0;
            err_b_orphan  <= 1'b0;
            err_r_orphan  <= 1'b0;
        end else begin
            b_orphan_prev <= b_orphan_now;
            r_orphan_prev <= r_orphan_now;
            if (b_orphan_now && b_orphan_prev) begin
                err_b_orphan <= 1'b1;
            end
            if (r_orphan_now && r_orphan_prev) begin
                err_r_orphan <= 1'b1;
            end
        end
    end
`else
    assign err_b_orphan = 1'b0;
    assign err_r_orphan = 1'b0;
`endif

endmodule
